// File: rtl/reset_controller.sv
// Board reset sequencer: stretches external reset, debounces a push-button, drives SOC reset_o/ready_o.
// Latency: reset_o low CYCLES edges after `reset` falls; press to reset_o high is 2+DEBOUNCE_CYCLES+1 edges.
// No flow control; all outputs are registered levels. Optional RESET_CAUSE_EN adds cause and press-count ports.
module reset_controller #(
    parameter int CYCLES             = 20,
    parameter int DEBOUNCE_CYCLES    = 1000000,
    parameter bit BUTTON_ACTIVE_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_i,
    output logic       reset_o,
    output logic       ready_o,
`ifdef RESET_CAUSE_EN
    output logic [1:0] reset_cause_o,
    output logic [7:0] button_reset_count_o,
`endif
    output logic       button_db_o
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    typedef enum logic [1:0] {HOLD, RUN, WAIT_RELEASE} state_t;

    state_t            state, next_state;
    logic              pressed;
    logic              sync_q1;
    logic              btn_sync;
    logic              btn_db;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              db_flip;
    logic              db_fall;
    logic              hold_done;

    assign pressed   = button_i ~^ BUTTON_ACTIVE_HIGH;
    assign db_flip   = (btn_sync != btn_db) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign db_fall   = db_flip && btn_db;
    assign hold_done = (hold_cnt == HOLD_W'(CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1  <= 1'b0;
            btn_sync <= 1'b0;
            btn_db   <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync_q1  <= pressed;
            btn_sync <= sync_q1;
            if (btn_sync == btn_db) begin
                db_cnt <= '0;
            end else if (db_flip) begin
                btn_db <= btn_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Leaving WAIT_RELEASE on the debounced-release edge itself makes the
    // post-release hold exactly CYCLES edges, matching the power-on case.
    always_comb begin
        next_state = state;
        case (state)
            HOLD:         if (hold_done) next_state = btn_db ? WAIT_RELEASE : RUN;
            RUN:          if (btn_db) next_state = WAIT_RELEASE;
            WAIT_RELEASE: if (!btn_db || db_fall) next_state = HOLD;
            default:      next_state = HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= HOLD;
            hold_cnt <= '0;
            reset_o  <= 1'b1;
            ready_o  <= 1'b0;
        end else begin
            state    <= next_state;
            hold_cnt <= (state == HOLD && next_state == HOLD) ? hold_cnt + 1'b1 : '0;
            reset_o  <= (next_state != RUN);
            ready_o  <= (next_state == RUN);
        end
    end

    assign button_db_o = btn_db;

`ifdef RESET_CAUSE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reset_cause_o        <= 2'b01;
            button_reset_count_o <= 8'd0;
        end else begin
            if (next_state != state && next_state != RUN)
                reset_cause_o <= 2'b10;
            if (state == RUN && next_state == WAIT_RELEASE && button_reset_count_o != 8'hFF)
                button_reset_count_o <= button_reset_count_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reset_controller.sv
// Directed bench for reset_controller: expected output levels queued per step, compared after each edge.
module tb_reset_controller;

    logic clk;
    logic reset;
    logic btn, btn_n, btn1;
    logic rst_a, rdy_a, db_a;
    logic rst_n, rdy_n, db_n;
    logic rst_1, rdy_1, db_1;
`ifdef RESET_CAUSE_EN
    logic [1:0] cause_a, cause_n, cause_1;
    logic [7:0] count_a, count_n, count_1;
`endif

    reset_controller #(.CYCLES(20), .DEBOUNCE_CYCLES(8), .BUTTON_ACTIVE_HIGH(1'b1)) dut (
        .clk(clk), .reset(reset), .button_i(btn), .reset_o(rst_a), .ready_o(rdy_a),
`ifdef RESET_CAUSE_EN
        .reset_cause_o(cause_a), .button_reset_count_o(count_a),
`endif
        .button_db_o(db_a)
    );

    reset_controller #(.CYCLES(20), .DEBOUNCE_CYCLES(8), .BUTTON_ACTIVE_HIGH(1'b0)) dut_n (
        .clk(clk), .reset(reset), .button_i(btn_n), .reset_o(rst_n), .ready_o(rdy_n),
`ifdef RESET_CAUSE_EN
        .reset_cause_o(cause_n), .button_reset_count_o(count_n),
`endif
        .button_db_o(db_n)
    );

    reset_controller #(.CYCLES(1), .DEBOUNCE_CYCLES(8), .BUTTON_ACTIVE_HIGH(1'b1)) dut1 (
        .clk(clk), .reset(reset), .button_i(btn1), .reset_o(rst_1), .ready_o(rdy_1),
`ifdef RESET_CAUSE_EN
        .reset_cause_o(cause_1), .button_reset_count_o(count_1),
`endif
        .button_db_o(db_1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {reset_o, ready_o, button_db_o}
    localparam logic [2:0] IN_RST  = 3'b100;
    localparam logic [2:0] RUNNING = 3'b010;
    localparam logic [2:0] RUN_DB  = 3'b011;
    localparam logic [2:0] WAIT_DB = 3'b101;

    typedef struct {
        int          sel;
        string       tag;
        logic [9:0]  exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    function automatic logic [9:0] obs(input int sel);
        case (sel)
            0: obs = {7'd0, rst_a, rdy_a, db_a};
            1: obs = {7'd0, rst_n, rdy_n, db_n};
            2: obs = {7'd0, rst_1, rdy_1, db_1};
`ifdef RESET_CAUSE_EN
            3: obs = {cause_n, count_n};
            4: obs = {cause_a, count_a};
            5: obs = {cause_1, count_1};
`endif
            default: obs = '1;
        endcase
    endfunction

    task automatic expect_(input int sel, input string tag, input logic [9:0] e);
        sb_t t;
        t.sel = sel;
        t.tag = tag;
        t.exp = e;
        sb_q.push_back(t);
    endtask

    task automatic drain();
        sb_t t;
        while (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            checks++;
            assert (obs(t.sel) === t.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", t.tag, obs(t.sel), t.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic run(input int sel, input string tag, input int n, input logic [2:0] e);
        for (int i = 0; i < n; i++) begin
            expect_(sel, tag, {7'd0, e});
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        btn   = 1'b0;
        btn_n = 1'b1;
        btn1  = 1'b0;

        // Power-on: reset state, then CYCLES-edge hold
        #1;
        expect_(0, "por_async", {7'd0, IN_RST});
        expect_(1, "por_async_n", {7'd0, IN_RST});
        expect_(2, "por_async_1", {7'd0, IN_RST});
        drain();
        run(0, "por_in_reset", 5, IN_RST);
        reset = 1'b0;
        expect_(0, "por_hold", {7'd0, IN_RST});
        expect_(2, "cycles1_release", {7'd0, RUNNING});
        tick();
        run(0, "por_hold", 18, IN_RST);
        run(0, "por_release", 1, RUNNING);
`ifdef RESET_CAUSE_EN
        expect_(3, "cause_por", {2'b01, 8'd0});
        drain();
`endif
        run(0, "run_idle", 5, RUNNING);

        // Bounce rejection: 5-cycle pulses shorter than debounce window
        for (int k = 0; k < 3; k++) begin
            btn = 1'b1;
            run(0, "bounce_hi", 5, RUNNING);
            btn = 1'b0;
            run(0, "bounce_gap", 2, RUNNING);
        end
        run(0, "bounce_settle", 6, RUNNING);

        // Clean press and release
        btn = 1'b1;
        run(0, "press_pre", 9, RUNNING);
        run(0, "press_db", 1, RUN_DB);
        run(0, "press_rst", 30, WAIT_DB);
        btn = 1'b0;
        run(0, "rel_pre", 9, WAIT_DB);
        run(0, "rel_db", 1, IN_RST);
        run(0, "rel_hold", 19, IN_RST);
        run(0, "rel_run", 1, RUNNING);

        // Press held through the power-on hold
        reset = 1'b1;
        #1;
        expect_(0, "por2_async", {7'd0, IN_RST});
        drain();
        run(0, "por2_in_reset", 3, IN_RST);
        reset = 1'b0;
        btn   = 1'b1;
        run(0, "por2_pre", 9, IN_RST);
        run(0, "por2_db", 51, WAIT_DB);
        btn = 1'b0;
        run(0, "por2_rel", 9, WAIT_DB);
        run(0, "por2_hold", 20, IN_RST);
        run(0, "por2_run", 1, RUNNING);

        // Async reset at hold count 12 restarts a full hold
        reset = 1'b1;
        #1;
        expect_(0, "arst_now", {7'd0, IN_RST});
        drain();
        run(0, "arst_in_reset", 3, IN_RST);
        reset = 1'b0;
        run(0, "arst_hold12", 12, IN_RST);
        reset = 1'b1;
        #1;
        expect_(0, "arst_mid_hold", {7'd0, IN_RST});
        drain();
        run(0, "arst_in_reset2", 3, IN_RST);
        reset = 1'b0;
        expect_(0, "arst_full_hold", {7'd0, IN_RST});
        expect_(2, "cycles1_rerelease", {7'd0, RUNNING});
        tick();
        run(0, "arst_full_hold", 18, IN_RST);
        run(0, "arst_run", 1, RUNNING);

        // Active-low button instance
        btn_n = 1'b0;
        run(1, "low_pre", 9, RUNNING);
        run(1, "low_db", 1, RUN_DB);
        run(1, "low_rst", 10, WAIT_DB);
        btn_n = 1'b1;
        run(1, "low_rel", 9, WAIT_DB);
        run(1, "low_rel_db", 1, IN_RST);
        run(1, "low_hold", 19, IN_RST);
        run(1, "low_run", 1, RUNNING);
`ifdef RESET_CAUSE_EN
        expect_(3, "cause_button", {2'b10, 8'd1});
        expect_(4, "cause_main", {2'b01, 8'd0});
        expect_(5, "cause_cycles1", {2'b01, 8'd0});
        drain();
`endif
        run(2, "cycles1_steady", 3, RUNNING);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
